// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - serialises a 9-bit parity word as start/8 data/parity/stop
// and pulses par_err when the received parity does not match the data.
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       par_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [8:0]  shreg;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        bit_end;

  assign bit_end = (baud_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= 9'd0;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      din_ready <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_err <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= 16'd0;
          bit_cnt  <= 3'd0;
          if (din_valid && din_ready) begin
            shreg     <= din;
            par_err   <= din[8] ^ (^din[7:0]);
            state     <= START;
            busy      <= 1'b1;
            din_ready <= 1'b0;
            tx        <= 1'b0;
          end else begin
            din_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            tx       <= shreg[0];
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            // After the seventh shift shreg[1] holds the parity bit.
            shreg    <= {1'b0, shreg[8:1]};
            tx       <= shreg[1];
            baud_cnt <= 16'd0;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state     <= IDLE;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            baud_cnt  <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          tx        <= 1'b1;
          busy      <= 1'b0;
          din_ready <= 1'b0;
          baud_cnt  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// tb/tb_parity_serial_tx.sv - directed bench for parity_serial_tx with N=4,
// frame period 45 cycles.
module tb_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] din = 9'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       par_err;

  int  tests = 0;
  int  fails = 0;
  time last_acc = 0;

  parity_serial_tx #(.CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Starts at a negedge with din_ready expected high, ends at the negedge of E+45.
  // bits[i] is the expected tx level in bit slot i (start, d0..d7, parity, stop).
  task automatic send_frame(input logic [8:0] w, input logic [10:0] bits,
                            input logic exp_err, input logic hold);
    logic exp_tx;
    tests++;
    if (din_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_accept: got %b want 1", din_ready);
    end
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    last_acc = $time;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) din_valid = 1'b0;
      if (k == 12) din = ~w;
      if (k == 20 && !hold) din_valid = 1'b1;
      if (k == 21 && !hold) din_valid = 1'b0;
      exp_tx = bits[(k - 1) / 4];
      tests++;
      if (tx !== exp_tx) begin
        fails++;
        $display("FAIL tx_bit w=%h cycle E+%0d: got %b want %b", w, k, tx, exp_tx);
      end
      tests++;
      if (par_err !== ((k == 1) ? exp_err : 1'b0)) begin
        fails++;
        $display("FAIL par_err w=%h cycle E+%0d: got %b want %b", w, k, par_err,
                 (k == 1) ? exp_err : 1'b0);
      end
      tests++;
      if (busy !== 1'b1 || din_ready !== 1'b0) begin
        fails++;
        $display("FAIL busy_ready_in_frame w=%h cycle E+%0d: got busy=%b ready=%b want 1/0",
                 w, k, busy, din_ready);
      end
    end
    @(negedge clk);
    tests++;
    if (din_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1 || par_err !== 1'b0) begin
      fails++;
      $display("FAIL frame_end w=%h E+45: got ready=%b busy=%b tx=%b perr=%b want 1/0/1/0",
               w, din_ready, busy, tx, par_err);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || par_err !== 1'b0 || din_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_values: got tx=%b busy=%b perr=%b ready=%b want 1/0/0/0",
                 tx, busy, par_err, din_ready);
      end
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (din_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b want 0", din_ready);
    end
    @(negedge clk);
    tests++;
    if (din_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_release: got ready=%b tx=%b busy=%b want 1/1/0",
               din_ready, tx, busy);
    end
  endtask

  task automatic test_frames();
    send_frame(9'h0A5, 11'b101_0100_1010, 1'b0, 1'b0);
    send_frame(9'h107, 11'b110_0000_1110, 1'b0, 1'b0);
  endtask

  task automatic test_parity_error();
    send_frame(9'h007, 11'b100_0000_1110, 1'b1, 1'b0);
    send_frame(9'h1FF, 11'b111_1111_1110, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    time t0;
    send_frame(9'h0A5, 11'b101_0100_1010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      t0 = last_acc;
      if (i == 1) send_frame(9'h0A5, 11'b101_0100_1010, 1'b0, 1'b1);
      else        send_frame(9'h107, 11'b110_0000_1110, 1'b0, (i != 2));
      tests++;
      if ((last_acc - t0) != 450) begin
        fails++;
        $display("FAIL b2b_period %0d: got %0t want 450", i, last_acc - t0);
      end
    end
  endtask

  task automatic test_reset_midframe();
    din = 9'h0A5;
    din_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) din_valid = 1'b0;
    end
    // Cycle E+18 is inside data bit 3, which is 0 for 0xA5.
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL mid_bit3: got %b want 0", tx);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b0 || par_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got tx=%b busy=%b ready=%b perr=%b want 1/0/0/0",
               tx, busy, din_ready, par_err);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1) begin
        fails++;
        $display("FAIL tx_in_reset %0d: got %b want 1", i, tx);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b1) begin
        fails++;
        $display("FAIL no_resume %0d: got tx=%b busy=%b ready=%b want 1/0/1",
                 i, tx, busy, din_ready);
      end
    end
    send_frame(9'h107, 11'b110_0000_1110, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_parity_error();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Serialiser directly downstream of the parity generator. It accepts the generator's 9-bit word (bit 8 = parity, bits 7:0 = data) over a valid/ready handshake and transmits it on one line as an asynchronous frame: start, 8 data bits LSB first, parity, stop. It re-checks the parity of each accepted word and flags mismatches, and it transmits the word unchanged either way.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  9  word from the parity stage; din[8] is parity, din[7:0] is data.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle level 1.
- busy  output  1  a frame is in progress.
- par_err  output  1  one-cycle pulse: the accepted word had din[8] != XOR(din[7:0]).

## Operation
- Reset values while rst_n=0: state IDLE, tx=1, din_ready=0, busy=0, par_err=0, counters 0. Reset acts immediately, with no clock needed.
- din_ready is registered. It rises on the first clk edge after rst_n deasserts, and it is 1 only in IDLE.
- Transfer occurs on an edge where din_valid=1 and din_ready=1. On that edge:
  - din is latched into a 9-bit shift register.
  - State goes to START, busy goes to 1 and din_ready goes to 0.
  - par_err is loaded with din[8] XOR (^din[7:0]).
- par_err clears on the next edge, so it is exactly one cycle wide. The frame is sent regardless of par_err.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx = shift register bit 0. Data bits go out d0 to d7.
  - PARITY: tx = latched din[8].
  - STOP: tx=1.
- Transitions happen when the baud counter reaches CLKS_PER_BIT-1:
  - START → DATA.
  - DATA → DATA for 8 bits, shifting right each bit. A 3-bit counter tracks the bit, and DATA exits after bit index 7.
  - DATA → PARITY.
  - PARITY → STOP.
  - STOP → IDLE, with din_ready going to 1 and busy going to 0 on that same edge.
- The baud counter is 16-bit. It resets to 0 on every state change and on accept, and otherwise increments.
- din and din_valid are ignored outside the accept edge. Changes to them mid-frame do not affect the frame.
- din_valid held high continuously gives one frame per accept. Every frame requires a fresh IDLE cycle with din_ready=1.
- tx, busy and din_ready are driven directly from registers; there is no combinational path from din or din_valid to any output.

## Timing
- The accept edge is E, and N = CLKS_PER_BIT.
- tx=0 (start bit) in cycles E+1 .. E+N.
- Data bit k is on tx in cycles E+1+(k+1)N .. E+(k+2)N.
- Parity occupies E+1+9N .. E+10N, and stop occupies E+1+10N .. E+11N.
- din_ready=1 and busy=0 from cycle E+11N+1. The earliest next accept edge is E+11N+1, so back-to-back frames have a frame period of 11N+1 cycles.
- This gives one extra idle-high cycle between frames; the stop bit therefore lasts N+1 cycles when frames are back-to-back.
- par_err is high in cycle E+1 only.
- Reset asserted mid-frame aborts the frame: tx=1 at once, and no partial frame resumes after release.

## Test plan
- Reset, then release rst_n → tx=1, busy=0, par_err=0 throughout reset; din_ready=1 one cycle after release.
- N=4, din=9'h0A5 (0xA5 has four ones, so parity 0) → tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0,1; par_err stays 0; din_ready returns at E+45.
- N=4, din=9'h107 → data bits 1,1,1,0,0,0,0,0, parity 1, stop 1; par_err=0.
- N=4, din=9'h007 (wrong parity) → par_err high only at E+1; tx still carries parity bit 0.
- din_valid held high with alternating 9'h0A5 / 9'h107 → consecutive accept edges exactly 45 cycles apart; every frame bit-exact; din changes between accepts ignored.
- Assert rst_n=0 during data bit 3, release after 2 cycles → tx=1 immediately; no further low bits; a new word is accepted normally and transmitted as a complete frame.
